// File: rtl/ps4_priority_select.sv
// Fixed-priority grant selector: highest-indexed request wins, gated by en.
// Combinational grant/index/valid plus a one-cycle registered copy.
module ps4_priority_select #(
   parameter int WIDTH = 4,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] req,
   input  logic             en,
   output logic [WIDTH-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic [WIDTH-1:0] gnt_q,
   output logic [IDX_W-1:0] gnt_idx_q,
   output logic             gnt_vld_q
);

   logic [WIDTH-1:0] gnt_d;
   logic [IDX_W-1:0] gnt_idx_d;
   logic             gnt_vld_d;

   // Each bit is masked by any request above it; the top bit has no mask.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prio
      if (gi == WIDTH-1) begin : g_top
         assign gnt[gi] = en & req[gi];
      end else begin : g_lower
         assign gnt[gi] = en & req[gi] & ~(|req[WIDTH-1:gi+1]);
      end
   end

   // gnt is at most one-hot, so OR-ing the indices of set bits yields the encoding.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (gnt[i]) begin
            gnt_idx = gnt_idx | IDX_W'(i);
         end
      end
   end

   assign gnt_vld = |gnt;

   always_comb begin
      gnt_d     = gnt;
      gnt_idx_d = gnt_idx;
      gnt_vld_d = gnt_vld;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         gnt_vld_q <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_vld_q <= gnt_vld_d;
      end
   end

endmodule

// File: tb/tb_ps4_priority_select.sv
// Directed bench for ps4_priority_select: 4-bit and 8-bit instances, combinational
// and registered paths, enable gating and asynchronous reset.
module tb_ps4_priority_select;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic       en;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic [3:0] gnt_q;
   logic [1:0] gnt_idx_q;
   logic       gnt_vld_q;

   logic [7:0] req8;
   logic       en8;
   logic [7:0] gnt8;
   logic [2:0] gnt_idx8;
   logic       gnt_vld8;
   logic [7:0] gnt_q8;
   logic [2:0] gnt_idx_q8;
   logic       gnt_vld_q8;

   int checks = 0;
   int errors = 0;

   // Hand-derived expectations for req = 0..15 with en = 1.
   logic [3:0] exp_gnt_tbl [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010,
                                    4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                    4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                    4'b1000, 4'b1000, 4'b1000, 4'b1000};
   logic [1:0] exp_idx_tbl [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                    2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

   ps4_priority_select #(.WIDTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .en        (en),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_vld   (gnt_vld),
      .gnt_q     (gnt_q),
      .gnt_idx_q (gnt_idx_q),
      .gnt_vld_q (gnt_vld_q)
   );

   ps4_priority_select #(.WIDTH(8)) dut8 (
      .clock     (clock),
      .reset     (reset),
      .req       (req8),
      .en        (en8),
      .gnt       (gnt8),
      .gnt_idx   (gnt_idx8),
      .gnt_vld   (gnt_vld8),
      .gnt_q     (gnt_q8),
      .gnt_idx_q (gnt_idx_q8),
      .gnt_vld_q (gnt_vld_q8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      en    = 1'b0;
      req8  = '0;
      en8   = 1'b0;

      // Reset state of registered outputs
      @(posedge clock);
      #1;
      check("reset_gnt_q",     32'(gnt_q),     32'h0);
      check("reset_gnt_idx_q", 32'(gnt_idx_q), 32'h0);
      check("reset_gnt_vld_q", 32'(gnt_vld_q), 32'h0);
      check("reset_comb_gnt",  32'(gnt),       32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Exhaustive sweep, en = 1
      en = 1'b1;
      for (int r = 0; r < 16; r++) begin
         req = 4'(r);
         #1;
         check($sformatf("sweep_gnt_%0d", r),     32'(gnt),     32'(exp_gnt_tbl[r]));
         check($sformatf("sweep_idx_%0d", r),     32'(gnt_idx), 32'(exp_idx_tbl[r]));
         check($sformatf("sweep_vld_%0d", r),     32'(gnt_vld), (r == 0) ? 32'h0 : 32'h1);
      end

      // Single-hot walk
      req = 4'b1000; #1;
      check("walk_gnt_3", 32'(gnt), 32'h8); check("walk_idx_3", 32'(gnt_idx), 32'd3); check("walk_vld_3", 32'(gnt_vld), 32'h1);
      req = 4'b0100; #1;
      check("walk_gnt_2", 32'(gnt), 32'h4); check("walk_idx_2", 32'(gnt_idx), 32'd2); check("walk_vld_2", 32'(gnt_vld), 32'h1);
      req = 4'b0010; #1;
      check("walk_gnt_1", 32'(gnt), 32'h2); check("walk_idx_1", 32'(gnt_idx), 32'd1); check("walk_vld_1", 32'(gnt_vld), 32'h1);
      req = 4'b0001; #1;
      check("walk_gnt_0", 32'(gnt), 32'h1); check("walk_idx_0", 32'(gnt_idx), 32'd0); check("walk_vld_0", 32'(gnt_vld), 32'h1);

      // Enable gating
      req = 4'b1111; en = 1'b1; #1;
      check("en1_gnt", 32'(gnt), 32'h8); check("en1_vld", 32'(gnt_vld), 32'h1);
      en = 1'b0; #1;
      check("en0_gnt", 32'(gnt), 32'h0); check("en0_vld", 32'(gnt_vld), 32'h0); check("en0_idx", 32'(gnt_idx), 32'h0);
      req = 4'b0110; #1;
      check("en0_0110_gnt", 32'(gnt), 32'h0); check("en0_0110_vld", 32'(gnt_vld), 32'h0);

      // Registered path: start from a cleared registered state
      @(negedge clock);
      req = 4'b0000; en = 1'b1;
      @(negedge clock);
      check("preload_gnt_q", 32'(gnt_q), 32'h0);
      req = 4'b0110; #1;
      check("reg_comb_gnt",      32'(gnt),       32'h4);
      check("reg_before_gnt_q",  32'(gnt_q),     32'h0);
      check("reg_before_vld_q",  32'(gnt_vld_q), 32'h0);
      @(posedge clock); #1;
      check("reg_after_gnt_q",   32'(gnt_q),     32'h4);
      check("reg_after_idx_q",   32'(gnt_idx_q), 32'd2);
      check("reg_after_vld_q",   32'(gnt_vld_q), 32'h1);

      // Asynchronous reset between edges
      @(negedge clock); #2;
      reset = 1'b1; #1;
      check("arst_gnt_q",   32'(gnt_q),     32'h0);
      check("arst_idx_q",   32'(gnt_idx_q), 32'h0);
      check("arst_vld_q",   32'(gnt_vld_q), 32'h0);
      check("arst_gnt",     32'(gnt),       32'h4);
      check("arst_idx",     32'(gnt_idx),   32'd2);
      check("arst_vld",     32'(gnt_vld),   32'h1);
      @(posedge clock); #1;
      check("arst_hold_gnt_q", 32'(gnt_q), 32'h0);
      @(negedge clock);
      reset = 1'b0; #1;
      check("arst_rel_gnt_q", 32'(gnt_q), 32'h0);
      @(posedge clock); #1;
      check("reload_gnt_q", 32'(gnt_q),     32'h4);
      check("reload_idx_q", 32'(gnt_idx_q), 32'd2);
      check("reload_vld_q", 32'(gnt_vld_q), 32'h1);

      // WIDTH = 8 instance
      @(negedge clock);
      en8 = 1'b1; req8 = 8'b0101_0011; #1;
      check("w8_gnt", 32'(gnt8), 32'h40); check("w8_idx", 32'(gnt_idx8), 32'd6); check("w8_vld", 32'(gnt_vld8), 32'h1);
      req8 = 8'b1000_0001; #1;
      check("w8_top_gnt", 32'(gnt8), 32'h80); check("w8_top_idx", 32'(gnt_idx8), 32'd7);
      req8 = 8'b0000_0110; #1;
      check("w8_low_gnt", 32'(gnt8), 32'h04); check("w8_low_idx", 32'(gnt_idx8), 32'd2);
      @(posedge clock); #1;
      check("w8_reg_gnt_q", 32'(gnt_q8), 32'h04); check("w8_reg_idx_q", 32'(gnt_idx_q8), 32'd2);
      en8 = 1'b0; #1;
      check("w8_en0_gnt", 32'(gnt8), 32'h0); check("w8_en0_vld", 32'(gnt_vld8), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps4_priority_select.md
Name: ps4_priority_select

Overview:
- Fixed-priority grant selector: picks the highest-indexed asserted request and issues a one-hot grant when enabled.
- The combinational grant is the primary output and is consumed same-cycle by downstream arbitration logic.
- A registered copy of the grant, its binary index and a valid flag are also provided for pipelined consumers.
- Generalised over request width; default instance is 4 requests.

Parameters:
- WIDTH, 4, number of request/grant lines (>=2).
- IDX_W, $clog2(WIDTH), width of encoded grant index (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock (registered outputs only).
- reset  input  1  asynchronous, active-high reset (registered outputs only).
- req  input  WIDTH  request vector; bit WIDTH-1 is highest priority.
- en  input  1  global enable; 0 forces all grants to 0.
- gnt  output  WIDTH  combinational one-hot (or zero) grant.
- gnt_idx  output  IDX_W  combinational binary index of asserted gnt bit; 0 when none.
- gnt_vld  output  1  combinational, = |gnt.
- gnt_q  output  WIDTH  gnt registered on clock.
- gnt_idx_q  output  IDX_W  gnt_idx registered on clock.
- gnt_vld_q  output  1  gnt_vld registered on clock.

Behaviour:
- Clocking: single clock, asynchronous active-high reset, as already decided.
- Grant function: gnt[i] = en & req[i] & ~(req[WIDTH-1] | ... | req[i+1]).
  - For i = WIDTH-1, gnt[i] = en & req[i].
- Default 4-bit case:
  - gnt[3] = en&req[3]
  - gnt[2] = en&req[2]&~req[3]
  - gnt[1] = en&req[1]&~req[3:2]
  - gnt[0] = en&req[0]&~req[3:1]
- gnt is purely combinational: zero latency, no dependence on clock or reset.
- Must settle within the same delta/evaluation step as req/en changes; no latches.
- At most one gnt bit set at any time.
- req == 0 or en == 0 -> gnt == 0, gnt_vld == 0, gnt_idx == 0.
- Multiple requests -> only the highest index is granted; lower requests are ignored.
- Fixed priority: no fairness, rotation or history.
- gnt_idx = index of set gnt bit.
- Registered outputs:
  - On posedge clock: gnt_q <= gnt, gnt_idx_q <= gnt_idx, gnt_vld_q <= gnt_vld.
  - Latency exactly 1 cycle.
- Reset:
  - reset high, asynchronously -> gnt_q = 0, gnt_idx_q = 0, gnt_vld_q = 0 immediately.
  - Held at 0 while reset is high; the first capture is at the first rising clock after reset deasserts.
  - Reset mid-operation clears the registered outputs only; gnt/gnt_idx/gnt_vld continue to track req/en.
- Unknown (X) on req/en may propagate; no X-masking is required.
- Implementation:
  - Generic over WIDTH (loop/generate-based priority chain and encoder).
  - No hard-coded 4-bit equations in the parameterised path.

Test Plan:
- Exhaustive sweep, en=1, req=0000..1111 -> gnt matches the priority equation each step, e.g. 0101->0100, 0110->0100, 1110->1000, 1111->1000, 0011->0010, 0001->0001, 0000->0000.
- Single-hot walk with en=1, req=1000,0100,0010,0001 -> gnt equals req; gnt_idx=3,2,1,0; gnt_vld=1.
- Enable gating: req=1111, en 1->0 -> gnt 1000->0000, gnt_vld 1->0. Then req=0110 with en=0 -> gnt stays 0000.
- Registered path, req=0110, en=1:
  - gnt=0100 immediately.
  - gnt_q=0100, gnt_idx_q=2, gnt_vld_q=1 after the next posedge clock, not before.
- Async reset mid-run: with gnt_q=0100, assert reset between clock edges -> gnt_q/gnt_idx_q/gnt_vld_q=0 at once while gnt stays 0100. Deassert reset -> outputs reload on the next edge.
- WIDTH=8 instance, req=8'b0101_0011, en=1 -> gnt=0100_0000, gnt_idx=6.
